// File: rtl/round_controller.sv
// round_controller: game-round sequencer for the number-guessing design.
// Latches the secret and difficulty, drives the countdown timer's active-low
// reload, scores guesses and reports win/lose, hints, attempts and score.
module round_controller #(
    parameter int unsigned MAX_ATTEMPTS = 7,  // wrong in-range guesses allowed (1..15)
    parameter int unsigned TIMEOUT_VAL  = 0   // timer_count value meaning time expired
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       start,
    input  logic [1:0] max_digit,
    input  logic [6:0] secret,
    input  logic [6:0] guess,
    input  logic       guess_valid,
    input  logic [6:0] timer_count,
    output logic       timer_restart,
    output logic [1:0] timer_digit,
    output logic       playing,
    output logic       win,
    output logic       lose,
    output logic       hint_high,
    output logic       hint_low,
    output logic       out_of_range,
    output logic [3:0] attempts,
    output logic [6:0] score
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PLAY,
        ST_WIN,
        ST_LOSE
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] secret_q, secret_d;
    logic [1:0] digit_q, digit_d;
    logic [3:0] attempts_q, attempts_d;
    logic [6:0] score_q, score_d;
    logic       hint_high_q, hint_high_d;
    logic       hint_low_q, hint_low_d;
    logic       oor_q, oor_d;
    logic       grace_q;
    logic       timer_restart_q, playing_q, win_q, lose_q;

    logic [6:0] limit;
    logic [3:0] attempts_inc;
    logic       begin_round;
    logic       expired;

    // Largest legal guess for the latched difficulty.
    always_comb begin
        case (digit_q)
            2'd2:    limit = 7'd99;
            2'd3:    limit = 7'd127;
            default: limit = 7'd9;
        endcase
    end

    assign attempts_inc = (attempts_q == 4'hF) ? 4'hF : attempts_q + 4'd1;
    assign expired      = (timer_count == 7'(TIMEOUT_VAL)) && !grace_q;

    // Next-state and datapath update for the round sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        secret_d    = secret_q;
        digit_d     = digit_q;
        attempts_d  = attempts_q;
        score_d     = score_q;
        hint_high_d = hint_high_q;
        hint_low_d  = hint_low_q;
        oor_d       = 1'b0;
        begin_round = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin_round = 1'b1;
            end
            ST_ARM: begin
                // Start and guesses are deliberately ignored for this one cycle.
                state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (start) begin
                    begin_round = 1'b1;
                end else begin
                    if (guess_valid) begin
                        if (guess > limit) begin
                            oor_d = 1'b1;
                        end else if (guess == secret_q) begin
                            attempts_d  = attempts_inc;
                            score_d     = timer_count;
                            hint_high_d = 1'b0;
                            hint_low_d  = 1'b0;
                            state_d     = ST_WIN;
                        end else begin
                            attempts_d  = attempts_inc;
                            hint_high_d = (guess > secret_q);
                            hint_low_d  = (guess < secret_q);
                            if (attempts_inc >= 4'(MAX_ATTEMPTS)) state_d = ST_LOSE;
                        end
                    end
                    // A correct guess on the expiry cycle still wins.
                    if (state_d == ST_PLAY && expired) state_d = ST_LOSE;
                end
            end
            ST_WIN, ST_LOSE: begin
                if (start) begin_round = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (begin_round) begin
            secret_d    = secret;
            digit_d     = (max_digit == 2'd0) ? 2'd1 : max_digit;
            attempts_d  = 4'd0;
            score_d     = 7'd0;
            hint_high_d = 1'b0;
            hint_low_d  = 1'b0;
            state_d     = ST_ARM;
        end
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state_q         <= ST_IDLE;
            secret_q        <= 7'd0;
            digit_q         <= 2'd1;
            attempts_q      <= 4'd0;
            score_q         <= 7'd0;
            hint_high_q     <= 1'b0;
            hint_low_q      <= 1'b0;
            oor_q           <= 1'b0;
            grace_q         <= 1'b0;
            timer_restart_q <= 1'b0;
            playing_q       <= 1'b0;
            win_q           <= 1'b0;
            lose_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q         <= state_d;
            secret_q        <= secret_d;
            digit_q         <= digit_d;
            attempts_q      <= attempts_d;
            score_q         <= score_d;
            hint_high_q     <= hint_high_d;
            hint_low_q      <= hint_low_d;
            oor_q           <= oor_d;
            grace_q         <= (state_q == ST_ARM);
            timer_restart_q <= (state_d == ST_PLAY);
            playing_q       <= (state_d == ST_PLAY);
            win_q           <= (state_d == ST_WIN);
            lose_q          <= (state_d == ST_LOSE);
        end
    end

    assign timer_restart = timer_restart_q;
    assign timer_digit   = digit_q;
    assign playing       = playing_q;
    assign win           = win_q;
    assign lose          = lose_q;
    assign hint_high     = hint_high_q;
    assign hint_low      = hint_low_q;
    assign out_of_range  = oor_q;
    assign attempts      = attempts_q;
    assign score         = score_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller: directed scenarios followed by
// randomized play, all compared against a cycle-age based reference model.
module tb_round_controller;

    localparam int unsigned MAX_ATT = 7;
    localparam int unsigned TOUT    = 0;

    logic       clk = 1'b0;
    logic       restart;
    logic       start;
    logic [1:0] max_digit;
    logic [6:0] secret;
    logic [6:0] guess;
    logic       guess_valid;
    logic [6:0] timer_count;
    logic       timer_restart;
    logic [1:0] timer_digit;
    logic       playing, win, lose, hint_high, hint_low, out_of_range;
    logic [3:0] attempts;
    logic [6:0] score;

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    round_controller #(
        .MAX_ATTEMPTS(MAX_ATT),
        .TIMEOUT_VAL (TOUT)
    ) dut (
        .clk          (clk),
        .restart      (restart),
        .start        (start),
        .max_digit    (max_digit),
        .secret       (secret),
        .guess        (guess),
        .guess_valid  (guess_valid),
        .timer_count  (timer_count),
        .timer_restart(timer_restart),
        .timer_digit  (timer_digit),
        .playing      (playing),
        .win          (win),
        .lose         (lose),
        .hint_high    (hint_high),
        .hint_low     (hint_low),
        .out_of_range (out_of_range),
        .attempts     (attempts),
        .score        (score)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: a round is described by whether one exists, how many
    // cycles have passed since its start edge (0 = arming cycle) and its result.
    bit         m_run;
    int         m_age;
    int         m_res;      // 0 running, 1 won, 2 lost
    logic [6:0] m_secret;
    logic [1:0] m_digit;
    int         m_att;
    bit         m_hh, m_hl, m_oor;
    logic [6:0] m_score;

    function automatic int lim_of(input logic [1:0] d);
        return (d == 2'd1) ? 9 : (d == 2'd2) ? 99 : 127;
    endfunction

    function automatic void mdl_reset();
        m_run = 0; m_age = 0; m_res = 0; m_secret = 0; m_digit = 2'd1;
        m_att = 0; m_hh = 0; m_hl = 0; m_oor = 0; m_score = 0;
    endfunction

    function automatic void mdl_step();
        bit arm, play;
        if (!restart) begin
            mdl_reset();
            return;
        end
        arm   = m_run && m_res == 0 && m_age == 0;
        play  = m_run && m_res == 0 && m_age >= 1;
        m_oor = 0;
        if (start && !arm) begin
            m_run = 1; m_age = 0; m_res = 0; m_secret = secret;
            m_digit = (max_digit == 2'd0) ? 2'd1 : max_digit;
            m_att = 0; m_hh = 0; m_hl = 0; m_score = 0;
        end else if (arm) begin
            m_age = 1;
        end else if (play) begin
            if (guess_valid) begin
                if (int'(guess) > lim_of(m_digit)) m_oor = 1;
                else if (guess == m_secret) begin
                    m_att = (m_att < 15) ? m_att + 1 : 15;
                    m_score = timer_count; m_hh = 0; m_hl = 0; m_res = 1;
                end else begin
                    m_att = (m_att < 15) ? m_att + 1 : 15;
                    m_hh = guess > m_secret; m_hl = guess < m_secret;
                    if (m_att >= int'(MAX_ATT)) m_res = 2;
                end
            end
            if (m_res == 0 && m_age >= 2 && int'(timer_count) == int'(TOUT)) m_res = 2;
            if (m_age < 1000) m_age++;
        end
    endfunction

    task automatic check_all(input string ctx);
        bit p;
        p = m_run && m_res == 0 && m_age >= 1;
        check({ctx, ".playing"},       playing,       32'(p));
        check({ctx, ".timer_restart"}, timer_restart, 32'(p));
        check({ctx, ".win"},           win,           32'(m_res == 1));
        check({ctx, ".lose"},          lose,          32'(m_res == 2));
        check({ctx, ".timer_digit"},   timer_digit,   32'(m_digit));
        check({ctx, ".hint_high"},     hint_high,     32'(m_hh));
        check({ctx, ".hint_low"},      hint_low,      32'(m_hl));
        check({ctx, ".out_of_range"},  out_of_range,  32'(m_oor));
        check({ctx, ".attempts"},      attempts,      32'(m_att));
        check({ctx, ".score"},         score,         32'(m_score));
    endtask

    task automatic drive(input bit st, input logic [1:0] md, input logic [6:0] sec,
                         input bit gv, input logic [6:0] g, input logic [6:0] tc);
        start = st; max_digit = md; secret = sec; guess_valid = gv; guess = g; timer_count = tc;
    endtask

    // One clock: model consumes the inputs present at the edge, then compare.
    task automatic step(input string ctx);
        mdl_step();
        @(posedge clk);
        #1;
        check_all(ctx);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic async_reset(input string ctx);
        restart = 1'b0;
        #1;
        mdl_reset();
        check_all(ctx);
        step({ctx, "_held"});
        restart = 1'b1;
    endtask

    initial begin
        logic [6:0] tc_win;
        int r, lim;
        restart = 1'b0;
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'd100);
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        restart = 1'b1;

        // Start: secret 42, two digits; ARM for one cycle, then PLAY.
        drive(1, 2'd2, 7'd42, 0, 7'd0, 7'd100);
        step("arm");
        check("arm.timer_restart_low", timer_restart, 32'd0);
        drive(0, 2'd2, 7'd0, 0, 7'd0, 7'd99);
        step("play_enter");
        check("play.timer_restart_high", timer_restart, 32'd1);

        // Guesses 50, 30, 42: high hint, low hint, then win.
        drive(0, 2'd2, 7'd0, 1, 7'd50, 7'd98);
        step("g50");
        check("g50.hint_high_const", hint_high, 32'd1);
        drive(0, 2'd2, 7'd0, 1, 7'd30, 7'd97);
        step("g30");
        check("g30.hint_low_const", hint_low, 32'd1);
        tc_win = 7'd77;
        drive(0, 2'd2, 7'd0, 1, 7'd42, tc_win);
        step("g42");
        check("g42.attempts_const", attempts, 32'd3);
        check("g42.score_const", score, 32'(tc_win));
        drive(0, 2'd2, 7'd0, 1, 7'd42, 7'd50);
        step("win_hold");

        // One digit, secret 5, guess 12 is out of range.
        drive(1, 2'd1, 7'd5, 0, 7'd0, 7'd90);
        step("oor_arm");
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'd90);
        step("oor_play");
        drive(0, 2'd0, 7'd0, 1, 7'd12, 7'd89);
        step("oor_pulse");
        check("oor.pulse_const", out_of_range, 32'd1);
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'd88);
        step("oor_clear");
        check("oor.attempts_const", attempts, 32'd0);

        // Seven wrong guesses lose; the eighth is ignored.
        drive(1, 2'd3, 7'd120, 0, 7'd0, 7'd80);
        step("max_arm");
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'd80);
        step("max_play");
        for (int i = 0; i < 8; i++) begin
            drive(0, 2'd0, 7'd0, 1, 7'(i * 3), 7'(79 - i));
            step("max_guess");
        end
        check("max.lose_const", lose, 32'd1);
        check("max.attempts_const", attempts, 32'(MAX_ATT));

        // Timer at expiry from ARM on: grace cycle survives, correct guess then wins with score 0.
        drive(1, 2'd2, 7'd33, 0, 7'd0, 7'(TOUT));
        step("to_arm");
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'(TOUT));
        step("to_play");
        step("to_grace");
        check("to.grace_playing_const", playing, 32'd1);
        drive(0, 2'd0, 7'd0, 1, 7'd33, 7'(TOUT));
        step("to_win");
        check("to.win_const", win, 32'd1);
        check("to.score_const", score, 32'(TOUT));

        // Same without a guess: lose on the cycle after grace.
        drive(1, 2'd2, 7'd60, 0, 7'd0, 7'(TOUT));
        step("to2_arm");
        drive(0, 2'd0, 7'd0, 0, 7'd0, 7'(TOUT));
        step("to2_play");
        step("to2_grace");
        step("to2_lose");
        check("to2.lose_const", lose, 32'd1);

        // Reset mid-PLAY; a guess afterwards does nothing until a new start.
        drive(1, 2'd3, 7'd70, 0, 7'd0, 7'd60);
        step("rst_arm");
        drive(0, 2'd0, 7'd0, 1, 7'd71, 7'd59);
        step("rst_play");
        step("rst_guess");
        async_reset("rst_mid");
        check("rst.timer_digit_const", timer_digit, 32'd1);
        drive(0, 2'd0, 7'd0, 1, 7'd70, 7'd58);
        step("rst_idle_guess");
        check("rst.idle_playing_const", playing, 32'd0);

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            r   = int'($urandom_range(0, 99));
            lim = lim_of(m_digit);
            start       = (r < 4);
            max_digit   = 2'($urandom_range(0, 3));
            secret      = 7'($urandom_range(0, lim_of(max_digit) + 4 > 127 ? 127 : lim_of(max_digit) + 4));
            guess_valid = ($urandom_range(0, 99) < 45);
            guess       = ($urandom_range(0, 99) < 30) ? m_secret
                        : 7'($urandom_range(0, lim + 8 > 127 ? 127 : lim + 8));
            timer_count = ($urandom_range(0, 14) == 0) ? 7'(TOUT) : 7'($urandom_range(1, 127));
            if ($urandom_range(0, 399) == 0) async_reset("rnd_rst");
            else step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
